// File: rtl/sls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sls_pkg
//  Description : Shared definitions for the single load/store memory
//                sequencer: FSM state encoding, RAM data-size codes,
//                instruction-register field positions, the decoded-settings
//                record and an alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sls_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_DONES = 3'd4;
    localparam state_t ST_ERRS  = 3'd5;

    // RAM data-size codes
    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    // Instruction-register bit positions
    localparam int IR_L = 20;   // load / store
    localparam int IR_B = 22;   // byte (mode 2)
    localparam int IR_S = 6;    // signed (mode 3)
    localparam int IR_H = 5;    // halfword (mode 3)

    // Decoded RAM settings for one request
    typedef struct packed {
        logic       rw;         // 1 = read
        logic       se;         // sign-extend read data
        logic [1:0] ds;         // data size
        logic       dbl;        // doubleword: two word beats
        logic       illegal;    // not a recognised load/store
    } dec_t;

    // Word and doubleword need a 4-byte aligned address, halfword 2-byte.
    function automatic logic misaligned(input logic [1:0] ds,
                                        input logic       dbl,
                                        input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        if (dbl || (ds == DS_WORD)) begin
            bad = (lsb != 2'b00);
        end else if (ds == DS_HALF) begin
            bad = lsb[0];
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sls_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sls_decode
//  Description : Combinational decode of IR[27:0] into RAM settings for
//                addressing mode 2 (word/byte) and mode 3 (halfword, signed,
//                doubleword) loads and stores.
//  Ports       : ir   in  28      instruction register bits 27..0
//                dec  out dec_t   {rw, se, ds, dbl, illegal}
//  Revision    : 1.0 - initial release
// ============================================================================
module sls_decode
    import sls_pkg::*;
(
    input  logic [27:0] ir,
    output dec_t        dec
);

    // Bits outside the opcode/L/B/S/H fields do not influence the RAM settings.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[24:23], ir[21], ir[19:8], ir[3:0]};

    always_comb begin
        dec         = '0;
        dec.illegal = 1'b1;
        if (ir[27:26] == 2'b01) begin
            // Mode 2: word or unsigned byte
            dec.illegal = 1'b0;
            dec.rw      = ir[IR_L];
            dec.ds      = ir[IR_B] ? DS_BYTE : DS_WORD;
        end else if ((ir[27:25] == 3'b000) && ir[7] && ir[4]) begin
            // Mode 3: selected by {L, S, H}
            case ({ir[IR_L], ir[IR_S], ir[IR_H]})
                3'b101: begin   // LDRH
                    dec.illegal = 1'b0;
                    dec.rw      = 1'b1;
                    dec.ds      = DS_HALF;
                end
                3'b110: begin   // LDRSB
                    dec.illegal = 1'b0;
                    dec.rw      = 1'b1;
                    dec.se      = 1'b1;
                    dec.ds      = DS_BYTE;
                end
                3'b111: begin   // LDRSH
                    dec.illegal = 1'b0;
                    dec.rw      = 1'b1;
                    dec.se      = 1'b1;
                    dec.ds      = DS_HALF;
                end
                3'b001: begin   // STRH
                    dec.illegal = 1'b0;
                    dec.ds      = DS_HALF;
                end
                3'b010: begin   // LDRD
                    dec.illegal = 1'b0;
                    dec.rw      = 1'b1;
                    dec.ds      = DS_WORD;
                    dec.dbl     = 1'b1;
                end
                3'b011: begin   // STRD
                    dec.illegal = 1'b0;
                    dec.ds      = DS_WORD;
                    dec.dbl     = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sls_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sls_mem_sequencer
//  Description : Sequences single load/store RAM accesses (addressing modes
//                2 and 3). Latches decoded settings and address on START,
//                drives the RAM MOV/MFC handshake and splits doubleword
//                transfers into two word beats.
//  Config      : SLS_TIMEOUT_EN - when defined, a WAIT watchdog aborts the
//                access with ERR after TIMEOUT_CYCLES cycles without MFC.
//  Ports       : CLK       in   1       clock, rising edge
//                RESET     in   1       asynchronous active-high reset
//                START     in   1       request pulse, honoured in IDLE only
//                IR        in   32      instruction register
//                ADDR_IN   in   ADDR_W  effective address, sampled with START
//                RAM_MFC   in   1       memory function complete
//                RAM_MOV   out  1       memory operation valid
//                RAM_RW    out  1       1 = read, 0 = write
//                RAM_SE    out  1       sign-extend read data
//                RAM_DS    out  2       00 byte, 01 half, 10 word
//                RAM_ADDR  out  ADDR_W  current beat address
//                BEAT      out  1       second word of a doubleword
//                BUSY      out  1       not IDLE
//                DONE      out  1       completion pulse
//                ERR       out  1       illegal/misaligned/timeout pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module sls_mem_sequencer
    import sls_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic              RAM_MFC,
    output logic              RAM_MOV,
    output logic              RAM_RW,
    output logic              RAM_SE,
    output logic [1:0]        RAM_DS,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              BEAT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_t            state;
    state_t            next_state;
    dec_t              dec;
    logic              bad_request;
    logic              timeout;

    logic              rw_lat;
    logic              se_lat;
    logic [1:0]        ds_lat;
    logic              dbl_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic              beat_lat;

    // Condition field has no bearing on the RAM settings.
    logic unused_ir_cond;
    assign unused_ir_cond = ^IR[31:28];

    sls_decode u_decode (
        .ir  (IR[27:0]),
        .dec (dec)
    );

    assign bad_request = dec.illegal | misaligned(dec.ds, dec.dbl, ADDR_IN[1:0]);

`ifdef SLS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts completed WAIT cycles; ISSUE always precedes WAIT so clearing
    // there restarts the count for every beat.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // High during the last allowed WAIT cycle; MFC in that cycle still wins.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog absent: never times out (parameter kept referenced).
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------
    // State register and latched settings
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            rw_lat   <= 1'b0;
            se_lat   <= 1'b0;
            ds_lat   <= DS_BYTE;
            dbl_lat  <= 1'b0;
            addr_lat <= '0;
            beat_lat <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && START) begin
                rw_lat   <= dec.rw;
                se_lat   <= dec.se;
                ds_lat   <= dec.ds;
                dbl_lat  <= dec.dbl;
                addr_lat <= ADDR_IN;
                beat_lat <= 1'b0;
            end else if (state == ST_GAP) begin
                beat_lat <= 1'b1;
                addr_lat <= addr_lat + ADDR_W'(4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = bad_request ? ST_ERRS : ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (RAM_MFC) begin
                    next_state = (dbl_lat && !beat_lat) ? ST_GAP : ST_DONES;
                end else if (timeout) begin
                    next_state = ST_ERRS;
                end
            end
            ST_GAP:   next_state = ST_ISSUE;
            ST_DONES: next_state = ST_IDLE;
            ST_ERRS:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        RAM_MOV = 1'b0;
        DONE    = 1'b0;
        ERR     = 1'b0;
        BUSY    = (state != ST_IDLE);
        case (state)
            ST_ISSUE, ST_WAIT: RAM_MOV = 1'b1;
            ST_DONES:          DONE    = 1'b1;
            ST_ERRS:           ERR     = 1'b1;
            default:           RAM_MOV = 1'b0;
        endcase
    end

    assign RAM_RW   = rw_lat;
    assign RAM_SE   = se_lat;
    assign RAM_DS   = ds_lat;
    assign RAM_ADDR = addr_lat;
    assign BEAT     = beat_lat;

endmodule
`default_nettype wire

// File: tb/tb_sls_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sls_mem_sequencer
//  Description : Self-checking bench for sls_mem_sequencer: table of directed
//                single/doubleword/error requests plus hand-written reset,
//                START-while-busy and WAIT-length sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sls_mem_sequencer;

    localparam int ADDR_W = 32;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              START;
    logic [31:0]       IR;
    logic [ADDR_W-1:0] ADDR_IN;
    logic              RAM_MFC;
    logic              RAM_MOV;
    logic              RAM_RW;
    logic              RAM_SE;
    logic [1:0]        RAM_DS;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              BEAT;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    int checks = 0;
    int errors = 0;

    sls_mem_sequencer #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .IR       (IR),
        .ADDR_IN  (ADDR_IN),
        .RAM_MFC  (RAM_MFC),
        .RAM_MOV  (RAM_MOV),
        .RAM_RW   (RAM_RW),
        .RAM_SE   (RAM_SE),
        .RAM_DS   (RAM_DS),
        .RAM_ADDR (RAM_ADDR),
        .BEAT     (BEAT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request: START in cycle 0, RAM answers MFC in the (d+1)-th WAIT
    // cycle of each beat (early=1 also drives MFC during ISSUE). 'again'
    // re-pulses START with a different request in that cycle.
    task automatic run_txn(input string name, input logic [31:0] ir, input logic [31:0] addr,
                           input int d, input bit early, input bit exp_err,
                           input bit exp_rw, input bit exp_se, input logic [1:0] exp_ds,
                           input int exp_end, input int exp_mov, input int again);
        int mov_cnt  = 0;
        int beat_cyc = 0;
        int beat_exp = 0;
        int end_cyc  = -1;
        bit ended    = 1'b0;
        bit got_err  = 1'b0;
        bit prev_mov = 1'b0;
        @(posedge CLK); #1;
        START   = 1'b1;
        IR      = ir;
        ADDR_IN = addr;
        RAM_MFC = 1'b0;
        for (int c = 1; c <= 80 && !ended; c++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (c == again) begin
                START   = 1'b1;
                IR      = 32'hE5C12000;
                ADDR_IN = 32'h0000_0055;
            end
            if (RAM_MOV) begin
                mov_cnt++;
                if (!prev_mov && mov_cnt > 1) beat_exp++;
                beat_cyc++;
                check({name, " rw"},   RAM_RW,   exp_rw);
                check({name, " se"},   RAM_SE,   exp_se);
                check({name, " ds"},   RAM_DS,   exp_ds);
                check({name, " beat"}, BEAT,     beat_exp);
                check({name, " addr"}, RAM_ADDR, addr + 32'(4 * beat_exp));
                check({name, " busy"}, BUSY,     1'b1);
            end else begin
                beat_cyc = 0;
            end
            prev_mov = RAM_MOV;
            if (DONE || ERR) begin
                ended   = 1'b1;
                end_cyc = c;
                got_err = ERR;
                check({name, " done_and_err"}, DONE & ERR, 1'b0);
            end
            RAM_MFC = RAM_MOV && ((beat_cyc >= d + 2) || early);
        end
        RAM_MFC = 1'b0;
        check({name, " end_cycle"}, end_cyc, exp_end);
        check({name, " err"},       got_err, exp_err);
        check({name, " mov_cycles"}, mov_cnt, exp_mov);
        @(posedge CLK); #1;
        START = 1'b0;
        check({name, " post_done"}, DONE,    1'b0);
        check({name, " post_err"},  ERR,     1'b0);
        check({name, " post_busy"}, BUSY,    1'b0);
        check({name, " post_mov"},  RAM_MOV, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] addr;
        int          d;
        bit          early;
        bit          err;
        bit          rw;
        bit          se;
        logic [1:0]  ds;
        int          end_c;
        int          mov;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //             name        ir            addr           d  e  err rw se ds     end mov
        vecs[0]  = '{"ldr",      32'hE5912000, 32'h0000_0100, 2, 0, 0,  1, 0, 2'b10, 5,  4};
        vecs[1]  = '{"ldrsh",    32'hE1D120F0, 32'h0000_0202, 0, 0, 0,  1, 1, 2'b01, 3,  2};
        vecs[2]  = '{"strb",     32'hE5C12000, 32'h0000_0103, 1, 0, 0,  0, 0, 2'b00, 4,  3};
        vecs[3]  = '{"ldrb",     32'hE5D12000, 32'h0000_0101, 0, 0, 0,  1, 0, 2'b00, 3,  2};
        vecs[4]  = '{"ldrh",     32'hE1D120B0, 32'h0000_0102, 3, 0, 0,  1, 0, 2'b01, 6,  5};
        vecs[5]  = '{"ldrsb",    32'hE1D120D0, 32'h0000_0007, 0, 0, 0,  1, 1, 2'b00, 3,  2};
        vecs[6]  = '{"strh",     32'hE1C120B0, 32'h0000_0020, 2, 0, 0,  0, 0, 2'b01, 5,  4};
        vecs[7]  = '{"str_mfc_in_issue", 32'hE5812000, 32'h0000_0000, 0, 1, 0, 0, 0, 2'b10, 3, 2};
        vecs[8]  = '{"ldrd_wrap", 32'hE1C120D0, 32'hFFFF_FFF8, 0, 0, 0, 1, 0, 2'b10, 6,  4};
        vecs[9]  = '{"strd",     32'hE1C120F0, 32'h0000_0040, 1, 0, 0,  0, 0, 2'b10, 8,  6};
        vecs[10] = '{"ldr_misal", 32'hE5912000, 32'h0000_0102, 0, 0, 1, 0, 0, 2'b00, 1,  0};
        vecs[11] = '{"illegal_mov", 32'hE1A00000, 32'h0000_0000, 0, 0, 1, 0, 0, 2'b00, 1, 0};
        vecs[12] = '{"ldrh_misal", 32'hE1D120B0, 32'h0000_0201, 0, 0, 1, 0, 0, 2'b00, 1, 0};
        vecs[13] = '{"ldrd_misal", 32'hE1C120D0, 32'h0000_0006, 0, 0, 1, 0, 0, 2'b00, 1, 0};
        vecs[14] = '{"illegal_l1s0h0", 32'hE1D12090, 32'h0000_0000, 0, 0, 1, 0, 0, 2'b00, 1, 0};

        RESET   = 1'b1;
        START   = 1'b0;
        IR      = 32'h0;
        ADDR_IN = '0;
        RAM_MFC = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset mov",  RAM_MOV,  1'b0);
        check("reset busy", BUSY,     1'b0);
        check("reset done", DONE,     1'b0);
        check("reset err",  ERR,      1'b0);
        check("reset addr", RAM_ADDR, 32'h0);
        check("reset ctl",  {RAM_RW, RAM_SE, RAM_DS, BEAT}, 5'b0);
        RESET = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].name, vecs[i].ir, vecs[i].addr, vecs[i].d, vecs[i].early,
                    vecs[i].err, vecs[i].rw, vecs[i].se, vecs[i].ds,
                    vecs[i].end_c, vecs[i].mov, -1);
        end

        // START while busy must not disturb the running LDR.
        run_txn("start_busy", 32'hE5912000, 32'h0000_0100, 3, 0, 0, 1, 0, 2'b10, 6, 5, 2);
        // START coinciding with DONE must be dropped.
        run_txn("start_at_done", 32'hE5812000, 32'h0000_0010, 1, 0, 0, 0, 0, 2'b10, 4, 3, 4);

        // Reset while in WAIT drops MOV/BUSY immediately.
        @(posedge CLK); #1;
        START   = 1'b1;
        IR      = 32'hE5912000;
        ADDR_IN = 32'h0000_0100;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        check("rst_wait pre mov", RAM_MOV, 1'b1);
        RESET = 1'b1;
        #1;
        check("rst_wait async mov",  RAM_MOV, 1'b0);
        check("rst_wait async busy", BUSY,    1'b0);
        @(posedge CLK); #1;
        check("rst_wait done", DONE, 1'b0);
        check("rst_wait err",  ERR,  1'b0);
        check("rst_wait addr", RAM_ADDR, 32'h0);
        RESET = 1'b0;
        run_txn("after_reset", 32'hE5912000, 32'h0000_0100, 2, 0, 0, 1, 0, 2'b10, 5, 4, -1);

`ifdef SLS_TIMEOUT_EN
        // MFC in the 15th WAIT cycle wins; MFC never -> ERR after 15 WAIT cycles.
        run_txn("mfc_last_cycle", 32'hE5912000, 32'h0000_0100, 14, 0, 0, 1, 0, 2'b10, 17, 16, -1);
        run_txn("timeout", 32'hE5912000, 32'h0000_0100, 100, 0, 1, 1, 0, 2'b10, 17, 16, -1);
`else
        // Without the watchdog a long WAIT simply completes.
        run_txn("long_wait", 32'hE5912000, 32'h0000_0100, 40, 0, 0, 1, 0, 2'b10, 43, 42, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
